// File: rtl/bht_ctrl.sv
// Branch history table controller: 2-bit saturating counters in a single-port
// table, an init sweep after reset/flush, and a small update queue that yields
// the table port to lookups until it fills.
module bht_ctrl #(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned QDEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             LOOKUP_VALID,
  input  logic [IDX_W-1:0] LOOKUP_IDX,
  output logic             LOOKUP_READY,
  output logic             PRED_VALID,
  output logic             PRED_TAKEN,
  input  logic             UPD_VALID,
  input  logic [IDX_W-1:0] UPD_IDX,
  input  logic             UPD_TAKEN,
  output logic             UPD_READY,
  output logic             INIT_BUSY
);

  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [1:0] CTR_WEAK = 2'b10;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;

  logic [1:0]       table_q [DEPTH];

  logic [IDX_W-1:0] q_idx [QDEPTH];
  logic             q_tkn [QDEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;

  logic             run, q_full, q_empty;
  logic             lookup_fire, upd_fire, upd_apply;
  logic [IDX_W-1:0] head_idx;
  logic             head_tkn;
  logic [1:0]       head_ctr;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_widx;
  logic [1:0]       tbl_wdata;

  // Handshakes: the port is only offered in RUN, and never in a flush cycle,
  // so nothing is accepted that the flush would immediately discard.
  assign run          = (state_q == ST_RUN);
  assign q_full       = (count == CNT_W'(QDEPTH));
  assign q_empty      = (count == '0);
  assign LOOKUP_READY = run & ~q_full & ~FLUSH;
  assign UPD_READY    = run & ~q_full & ~FLUSH;
  assign INIT_BUSY    = (state_q == ST_INIT);

  assign lookup_fire = LOOKUP_VALID & LOOKUP_READY;
  assign upd_fire    = UPD_VALID & UPD_READY;
  // A full queue blocks lookups, so the head update gets the port then too.
  assign upd_apply   = run & ~FLUSH & ~lookup_fire & ~q_empty;

  assign head_idx = q_idx[rd_ptr];
  assign head_tkn = q_tkn[rd_ptr];
  assign head_ctr = table_q[head_idx];

  // FSM state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  // FSM next state: sweep one index per cycle, flush restarts from index 0
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    if (FLUSH) begin
      state_d    = ST_INIT;
      init_idx_d = '0;
    end else if (state_q == ST_INIT) begin
      init_idx_d = init_idx_q + IDX_W'(1);
      if (&init_idx_q) state_d = ST_RUN;
    end
  end

  // Single table write port: sweep write or saturating read-modify-write
  always_comb begin
    tbl_we    = 1'b0;
    tbl_widx  = init_idx_q;
    tbl_wdata = CTR_WEAK;
    if ((state_q == ST_INIT) && !FLUSH) begin
      tbl_we = 1'b1;
    end else if (upd_apply) begin
      tbl_we   = 1'b1;
      tbl_widx = head_idx;
      if (head_tkn) tbl_wdata = (head_ctr == 2'b11) ? 2'b11 : head_ctr + 2'b01;
      else          tbl_wdata = (head_ctr == 2'b00) ? 2'b00 : head_ctr - 2'b01;
    end
  end

  // Counter table; reset parks every entry so nothing is written while RESET is low
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < int'(DEPTH); i++) table_q[i] <= CTR_WEAK;
    end else if (tbl_we) begin
      table_q[tbl_widx] <= tbl_wdata;
    end
  end

  // Update queue payload storage
  always_ff @(posedge CLK) begin
    if (upd_fire) begin
      q_idx[wr_ptr] <= UPD_IDX;
      q_tkn[wr_ptr] <= UPD_TAKEN;
    end
  end

  // Update queue pointers and occupancy; flush drops everything queued
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (upd_fire)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (upd_apply) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({upd_fire, upd_apply})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered prediction, one cycle after the lookup is accepted
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      PRED_VALID <= 1'b0;
      PRED_TAKEN <= 1'b0;
    end else begin
      PRED_VALID <= lookup_fire;
      PRED_TAKEN <= lookup_fire & table_q[LOOKUP_IDX][1];
    end
  end

endmodule

// File: doc/bht_ctrl.md
BHT_CTRL -- requirements
Module: bht_ctrl

Interface
REQ-001 Parameter IDX_W, default 6, table index width; the table SHALL hold 2^IDX_W entries.
REQ-002 Parameter QDEPTH, default 4, update-queue depth; the value SHALL be a power of two and at least 2.
REQ-003 CLK  input  1  clock; all state SHALL update on the rising edge.
REQ-004 RESET  input  1  reset, asynchronous, active-low.
REQ-005 FLUSH  input  1  synchronous request to restart initialisation.
REQ-006 LOOKUP_VALID  input  1  prediction request.
REQ-007 LOOKUP_IDX  input  IDX_W  table index to predict.
REQ-008 LOOKUP_READY  output  1  lookup accepted when LOOKUP_VALID and LOOKUP_READY are both high.
REQ-009 PRED_VALID  output  1  PRED_TAKEN is valid this cycle.
REQ-010 PRED_TAKEN  output  1  counter MSB read for the accepted lookup.
REQ-011 UPD_VALID  input  1  branch-resolution update request.
REQ-012 UPD_IDX  input  IDX_W  table index to update.
REQ-013 UPD_TAKEN  input  1  resolved branch outcome.
REQ-014 UPD_READY  output  1  update accepted into the queue when UPD_VALID and UPD_READY are both high.
REQ-015 INIT_BUSY  output  1  initialisation sweep in progress.

Function
REQ-016 Each table entry SHALL be a 2-bit saturating counter: taken increments, saturating at 11; not-taken decrements, saturating at 00.
REQ-017 Each entry's prediction SHALL be its MSB; the initial entry value SHALL be 10 (weakly taken).
REQ-018 The table SHALL be single-port: at most one access per cycle, either a lookup read or an update read-modify-write.
REQ-019 The FSM SHALL have two states, INIT and RUN.
REQ-020 INIT SHALL write 10 to index 0,1,...,2^IDX_W-1, one index per cycle; after the last index it SHALL go to RUN.
REQ-021 INIT SHALL take exactly 2^IDX_W cycles, with INIT_BUSY high throughout.
REQ-022 During INIT, LOOKUP_READY, UPD_READY and PRED_VALID SHALL be 0.
REQ-023 FLUSH high in any state SHALL, on the next edge, enter INIT at index 0 and empty the update queue; queued updates are discarded.
REQ-024 FLUSH high during INIT SHALL restart the sweep at index 0.
REQ-025 Accepted updates SHALL enter a FIFO of QDEPTH entries holding {UPD_IDX, UPD_TAKEN}, with an occupancy count of width log2(QDEPTH)+1.
REQ-026 UPD_READY SHALL be 1 in RUN when the queue is not full.
REQ-027 Enqueue and dequeue in the same cycle SHALL leave the occupancy unchanged.
REQ-028 Arbitration in RUN: an accepted lookup SHALL have the table access when the queue holds fewer than QDEPTH entries.
REQ-029 When the queue is full, the head update SHALL have the table access and LOOKUP_READY SHALL be 0.
REQ-030 When no lookup is accepted and the queue is non-empty, the head update SHALL be applied and dequeued.
REQ-031 LOOKUP_READY SHALL be 1 in RUN when the queue is not full.
REQ-032 Lookup latency SHALL be 1 cycle: PRED_VALID and PRED_TAKEN SHALL be registered and asserted in the cycle after acceptance.
REQ-033 PRED_VALID SHALL be high for exactly one cycle per accepted lookup.
REQ-034 An update SHALL be visible to a lookup accepted in the cycle after that update is applied.
REQ-035 Updates still waiting in the queue SHALL NOT be bypassed to lookups.
REQ-036 Updates to the same index SHALL be applied in acceptance order.
REQ-037 An update arriving while the queue is full SHALL see UPD_READY=0 and SHALL NOT be lost by the block; the requester holds it.

Reset
REQ-038 RESET low SHALL immediately clear the queue, PRED_VALID and PRED_TAKEN, and select INIT at index 0.
REQ-039 While RESET is low, INIT_BUSY SHALL be 1 and LOOKUP_READY and UPD_READY SHALL be 0.
REQ-040 After RESET rises, the sweep SHALL proceed per REQ-020; the table contents are don't-care until the sweep completes.
REQ-041 RESET asserted mid-sweep or in RUN SHALL abort all activity with no further table writes.

Verification
REQ-042 Release reset with IDX_W=6 -> INIT_BUSY high for 64 cycles, then low; a lookup of every index returns PRED_TAKEN=1.
REQ-043 Apply 3 not-taken updates to idx 5, let the queue drain, then look up idx 5 -> PRED_TAKEN=0; after 4 taken updates -> 1; a further 10 taken then 2 not-taken leaves the counter at 01 -> 0.
REQ-044 Hold LOOKUP_VALID high continuously while issuing 5 updates -> UPD_READY drops after 4; LOOKUP_READY drops for one cycle per forced update; all 5 updates are applied in order.
REQ-045 Assert FLUSH with 3 updates queued for idx 9 (not-taken) -> INIT re-runs for 64 cycles; then lookup idx 9 returns 1.
REQ-046 Drop RESET mid-sweep at index 30 -> outputs clear immediately; after release, a full 64-cycle sweep runs from index 0.
REQ-047 Accept a lookup and an update to the same idx in one cycle with the queue empty -> the prediction reflects the old value; the next lookup reflects the updated value.
